grey_pixel_sdram_packer: RTL and testbench

//   Downstream stage of the grey/Sobel image processing unit. Accepts its
//   12-bit pixel stream (data + valid) and buffers it in a small elastic FIFO.

---
 rtl/grey_pixel_sdram_packer.sv | 91 +++++++++
 tb/tb_grey_pixel_sdram_packer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/grey_pixel_sdram_packer.sv
// Elastic FIFO between the grey/Sobel pixel stream and the SDRAM write FIFOs.
// Each 10-bit grey value leaves as a pair of 16-bit R=G=B words.
module grey_pixel_sdram_packer #(
   parameter int DEPTH = 16,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [11:0]              iDATA,
   input  logic                     iDVAL,
   input  logic                     iSOF,
   output logic [15:0]              oWR_DATA1,
   output logic [15:0]              oWR_DATA2,
   output logic                     oWR_VALID,
   input  logic                     iWR_READY,
   output logic [$clog2(DEPTH):0]   oLEVEL,
   output logic                     oOVERFLOW,
   output logic [CNT_W-1:0]         oDROP_CNT,
   output logic [7:0]               oFRAME_CNT
);

   localparam int AW = $clog2(DEPTH);

   logic [9:0]       mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      level;
   logic [9:0]       head;
   logic             full;
   logic             sof;
   logic             wr_en;
   logic             rd_en;
   logic             drop;
   logic             unused_lsb;

   // Only the upper ten bits of the pixel are carried through to SDRAM.
   assign unused_lsb = ^iDATA[1:0];

   // Full is judged on the pre-edge level; a frame start always lands its pixel.
   assign full  = (level == (AW+1)'(DEPTH));
   assign sof   = iSOF & iDVAL;
   assign wr_en = iDVAL & (sof | ~full);
   assign drop  = iDVAL & full & ~sof;
   assign rd_en = oWR_VALID & iWR_READY & ~sof;

   // NOTE: the storage array is deliberately left without reset; emptiness is
   // tracked by level and the outputs are masked, so stale entries never leak.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= iDATA[11:2];
   end

   // NOTE: all state below uses non-blocking assignments so every register
   // samples pre-edge values, which the full/read rules depend on.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (sof) begin
         rd_ptr <= wr_ptr;
         wr_ptr <= wr_ptr + AW'(1);
         level  <= (AW+1)'(1);
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         level <= level + (AW+1)'(wr_en) - (AW+1)'(rd_en);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         oOVERFLOW  <= 1'b0;
         oDROP_CNT  <= '0;
         oFRAME_CNT <= '0;
      end else if (sof) begin
         oOVERFLOW  <= 1'b0;
         oDROP_CNT  <= '0;
         oFRAME_CNT <= oFRAME_CNT + 8'd1;
      end else if (drop) begin
         oOVERFLOW <= 1'b1;
         if (oDROP_CNT != '1) oDROP_CNT <= oDROP_CNT + CNT_W'(1);
      end
   end

   assign head      = mem[rd_ptr];
   assign oWR_VALID = (level != '0);
   assign oLEVEL    = level;
   assign oWR_DATA1 = oWR_VALID ? {1'b0, head[9:5], head} : 16'h0000;
   assign oWR_DATA2 = oWR_VALID ? {1'b0, head[4:0], head} : 16'h0000;

endmodule

// File: tb/tb_grey_pixel_sdram_packer.sv
// Directed bench for grey_pixel_sdram_packer: reset, single pixel, overflow,
// full+read, frame resync, randomised streaming with a queue scoreboard, frame wrap.
module tb_grey_pixel_sdram_packer;

   localparam int DEPTH = 16;
   localparam int CNT_W = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [11:0]       iDATA;
   logic              iDVAL;
   logic              iSOF;
   logic [15:0]       oWR_DATA1;
   logic [15:0]       oWR_DATA2;
   logic              oWR_VALID;
   logic              iWR_READY;
   logic [4:0]        oLEVEL;
   logic              oOVERFLOW;
   logic [CNT_W-1:0]  oDROP_CNT;
   logic [7:0]        oFRAME_CNT;

   int vectors     = 0;
   int miscompares = 0;

   logic [9:0]  q[$];
   int          drops_m;
   logic        ovf_m;
   logic [7:0]  frame_m;

   grey_pixel_sdram_packer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .iDATA      (iDATA),
      .iDVAL      (iDVAL),
      .iSOF       (iSOF),
      .oWR_DATA1  (oWR_DATA1),
      .oWR_DATA2  (oWR_DATA2),
      .oWR_VALID  (oWR_VALID),
      .iWR_READY  (iWR_READY),
      .oLEVEL     (oLEVEL),
      .oOVERFLOW  (oOVERFLOW),
      .oDROP_CNT  (oDROP_CNT),
      .oFRAME_CNT (oFRAME_CNT)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] word1(input logic [9:0] v);
      return {1'b0, v[9:5], v};
   endfunction

   function automatic logic [15:0] word2(input logic [9:0] v);
      return {1'b0, v[4:0], v};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic sof_now;
      logic rd_now;
      logic [9:0] v;

      rst = 1'b0; iDATA = 12'h0; iDVAL = 1'b0; iSOF = 1'b0; iWR_READY = 1'b0;

      // Reset held: input activity must not disturb the empty state.
      for (int i = 0; i < 4; i++) begin
         iDVAL = ~iDVAL; iDATA = 12'hFFF; iSOF = 1'b1;
         step();
      end
      check("rst_valid", 32'(oWR_VALID), 32'd0);
      check("rst_level", 32'(oLEVEL), 32'd0);
      check("rst_drop", 32'(oDROP_CNT), 32'd0);
      check("rst_ovf", 32'(oOVERFLOW), 32'd0);
      check("rst_frame", 32'(oFRAME_CNT), 32'd0);
      check("rst_d1", 32'(oWR_DATA1), 32'd0);
      check("rst_d2", 32'(oWR_DATA2), 32'd0);
      iDVAL = 1'b0; iSOF = 1'b0;
      step();
      rst = 1'b1;
      step();

      // Single pixel.
      iDATA = 12'hABC; iDVAL = 1'b1;
      step();
      iDVAL = 1'b0;
      check("single_valid", 32'(oWR_VALID), 32'd1);
      check("single_d1", 32'(oWR_DATA1), 32'h56AF);
      check("single_d2", 32'(oWR_DATA2), 32'h3EAF);
      check("single_level", 32'(oLEVEL), 32'd1);
      iWR_READY = 1'b1;
      step();
      iWR_READY = 1'b0;
      check("single_empty_valid", 32'(oWR_VALID), 32'd0);
      check("single_empty_level", 32'(oLEVEL), 32'd0);
      check("single_empty_d1", 32'(oWR_DATA1), 32'd0);

      // Overflow: 20 pixels into a 16-deep FIFO with no reads.
      for (int i = 0; i < 20; i++) begin
         iDATA = 12'(i << 2); iDVAL = 1'b1;
         step();
      end
      iDVAL = 1'b0;
      check("ovf_level", 32'(oLEVEL), 32'd16);
      check("ovf_drop", 32'(oDROP_CNT), 32'd4);
      check("ovf_flag", 32'(oOVERFLOW), 32'd1);

      // Full + read in the same cycle: write still dropped, level falls to 15.
      check("fullrd_head", 32'(oWR_DATA1), 32'(word1(10'd0)));
      iDATA = 12'hFFC; iDVAL = 1'b1; iWR_READY = 1'b1;
      step();
      iDVAL = 1'b0;
      check("fullrd_level", 32'(oLEVEL), 32'd15);
      check("fullrd_drop", 32'(oDROP_CNT), 32'd5);

      // Drain the remainder in arrival order.
      for (int i = 1; i < 16; i++) begin
         check("drain_d1", 32'(oWR_DATA1), 32'(word1(10'(i))));
         check("drain_d2", 32'(oWR_DATA2), 32'(word2(10'(i))));
         step();
      end
      iWR_READY = 1'b0;
      check("drain_empty", 32'(oLEVEL), 32'd0);

      // Resync: build level 9 with 3 drops in a fresh frame, then frame start.
      iSOF = 1'b1; iDVAL = 1'b1; iDATA = 12'h000;
      step();
      iSOF = 1'b0;
      check("sof1_frame", 32'(oFRAME_CNT), 32'd1);
      check("sof1_drop", 32'(oDROP_CNT), 32'd0);
      check("sof1_ovf", 32'(oOVERFLOW), 32'd0);
      for (int i = 1; i < 19; i++) begin
         iDATA = 12'(i << 2);
         step();
      end
      iDVAL = 1'b0; iWR_READY = 1'b1;
      for (int i = 0; i < 7; i++) step();
      check("pre_resync_level", 32'(oLEVEL), 32'd9);
      check("pre_resync_drop", 32'(oDROP_CNT), 32'd3);
      iSOF = 1'b1; iDVAL = 1'b1; iDATA = 12'h400;
      step();
      iSOF = 1'b0; iDVAL = 1'b0; iWR_READY = 1'b0;
      check("resync_level", 32'(oLEVEL), 32'd1);
      check("resync_d1", 32'(oWR_DATA1), 32'h2100);
      check("resync_d2", 32'(oWR_DATA2), 32'h0100);
      check("resync_drop", 32'(oDROP_CNT), 32'd0);
      check("resync_ovf", 32'(oOVERFLOW), 32'd0);
      check("resync_frame", 32'(oFRAME_CNT), 32'd2);
      iWR_READY = 1'b1;
      step();
      iWR_READY = 1'b0;
      check("resync_drain", 32'(oLEVEL), 32'd0);

      // Streaming with a queue scoreboard.
      q.delete(); drops_m = 0; ovf_m = 1'b0; frame_m = 8'd2;
      for (int i = 0; i < 1000; i++) begin
         sof_now   = (i % 8 == 7);
         iDATA     = 12'($urandom_range(0, 4095));
         iDVAL     = 1'b1;
         iSOF      = sof_now;
         iWR_READY = 1'($urandom_range(0, 1));
         check("stream_valid", 32'(oWR_VALID), 32'(q.size() != 0));
         check("stream_level", 32'(oLEVEL), 32'(q.size()));
         if (q.size() != 0) begin
            check("stream_d1", 32'(oWR_DATA1), 32'(word1(q[0])));
            check("stream_d2", 32'(oWR_DATA2), 32'(word2(q[0])));
         end
         if (sof_now) check("stream_frame_drops", 32'(oDROP_CNT), 32'(drops_m));
         v = iDATA[11:2];
         rd_now = (q.size() != 0) && iWR_READY;
         if (sof_now) begin
            q.delete(); q.push_back(v);
            drops_m = 0; ovf_m = 1'b0; frame_m = frame_m + 8'd1;
         end else begin
            if (q.size() == DEPTH) begin
               drops_m++; ovf_m = 1'b1;
            end else begin
               q.push_back(v);
            end
            if (rd_now) void'(q.pop_front());
         end
         step();
      end
      iDVAL = 1'b0; iSOF = 1'b0; iWR_READY = 1'b0;
      check("stream_end_drop", 32'(oDROP_CNT), 32'(drops_m));
      check("stream_end_ovf", 32'(oOVERFLOW), 32'(ovf_m));
      check("stream_end_level", 32'(oLEVEL), 32'(q.size()));
      check("stream_end_frame", 32'(oFRAME_CNT), 32'(frame_m));

      // Frame counter wrap 255 -> 0.
      for (int k = 0; k < 256 && frame_m != 8'd255; k++) begin
         iSOF = 1'b1; iDVAL = 1'b1; iDATA = 12'h123;
         step();
         frame_m = frame_m + 8'd1;
      end
      check("frame_255", 32'(oFRAME_CNT), 32'd255);
      step();
      iSOF = 1'b0; iDVAL = 1'b0;
      check("frame_wrap", 32'(oFRAME_CNT), 32'd0);
      check("frame_wrap_level", 32'(oLEVEL), 32'd1);

      // Asynchronous reset mid-stream, observed without a clock edge.
      iDVAL = 1'b1; iDATA = 12'h800;
      step();
      #2 rst = 1'b0;
      #1;
      check("async_rst_level", 32'(oLEVEL), 32'd0);
      check("async_rst_valid", 32'(oWR_VALID), 32'd0);
      check("async_rst_frame", 32'(oFRAME_CNT), 32'd0);
      check("async_rst_d1", 32'(oWR_DATA1), 32'd0);
      iDVAL = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
